// File: rtl/ysyx_23060278_mcctl.sv
// rtl/ysyx_23060278_mcctl.sv - multi-cycle fetch/decode/exec/mem/wb sequencing controller
// Define YSYX_23060278_PERF_EN to add the cycle_cnt and instret performance counters.
module ysyx_23060278_mcctl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       ifu_req,
  input  logic       ifu_ready,
  output logic       ir_we,
  input  logic       dec_load,
  input  logic       dec_store,
  input  logic       dec_regwrite,
  input  logic       dec_ebreak,
  input  logic       dec_illegal,
  output logic       lsu_req,
  output logic       lsu_we,
  input  logic       lsu_ready,
  output logic       rf_we,
  output logic       pc_we,
  output logic       halt,
  output logic       err,
  output logic [2:0] state
`ifdef YSYX_23060278_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       err_q;
  logic       err_set;
  logic       load_q;
  logic       store_q;
  logic       regwrite_q;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       tmo_hit;

  // The limit is reached on the wait cycle that brings the count up to MEM_TIMEOUT.
  assign waiting = ((state_q == S_FETCH) && !ifu_ready) || ((state_q == S_MEM) && !lsu_ready);
  assign tmo_hit = (MEM_TIMEOUT != 8'd0) && (wait_cnt == MEM_TIMEOUT - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_ebreak) begin
          state_d = S_HALT;
        end else if (dec_illegal) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = (load_q || store_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_ready) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_set = 1'b1;
      end
    endcase
  end

  always_comb begin
    ifu_req = (state_q == S_FETCH);
    ir_we   = (state_q == S_FETCH) && ifu_ready;
    lsu_req = (state_q == S_MEM);
    lsu_we  = (state_q == S_MEM) && store_q;
    rf_we   = (state_q == S_WB) && regwrite_q && !store_q;
    pc_we   = (state_q == S_WB);
    halt    = (state_q == S_HALT);
    err     = err_q;
    state   = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      load_q     <= dec_load;
      store_q    <= dec_store;
      regwrite_q <= dec_regwrite;
    end
  end

  // Any state change clears the count, which covers entry into FETCH and MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state_d != state_q) begin
      wait_cnt <= 8'd0;
    end else if (waiting && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef YSYX_23060278_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 64'd0;
      instret   <= 64'd0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
      if (pc_we) begin
        instret <= instret + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060278_mcctl.sv
// tb/tb_ysyx_23060278_mcctl.sv - directed self-checking bench for ysyx_23060278_mcctl
// Expected per-cycle outputs come from expanding each instruction into its phase list.
module tb_ysyx_23060278_mcctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ifu_req, ifu_ready, ir_we;
  logic       dec_load, dec_store, dec_regwrite, dec_ebreak, dec_illegal;
  logic       lsu_req, lsu_we, lsu_ready;
  logic       rf_we, pc_we, halt, err;
  logic [2:0] state;
`ifdef YSYX_23060278_PERF_EN
  logic [63:0] cycle_cnt, instret;
  logic [63:0] cyc_m, ret_m;
`endif

  ysyx_23060278_mcctl #(.MEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ir_we(ir_we),
    .dec_load(dec_load), .dec_store(dec_store), .dec_regwrite(dec_regwrite),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .err(err), .state(state)
`ifdef YSYX_23060278_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifr;
    logic        lsr;
    logic [4:0]  fl;
    logic [10:0] exp;
  } ent_t;

  localparam logic [4:0] NZ = 5'b11111;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_no = 0;
  int          lg;
  logic [2:0]  st_log[32];
  logic [31:0] ir_m, pc_m, rf_m, lr_m, lw_m, if_m;

  function automatic logic [10:0] outs();
    return {state, ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halt, err};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic ifr, input logic lsr, input logic [4:0] fl,
                      input logic lst, input logic lrw, input logic er);
    ent_t e;
    e.ifr = ifr;
    e.lsr = lsr;
    e.fl  = fl;
    e.exp = {st, st == 3'd1, (st == 3'd1) && ifr, st == 3'd4, (st == 3'd4) && lst,
             (st == 3'd5) && lrw && !lst, st == 3'd5, st == 3'd6, er};
    q.push_back(e);
  endtask

  task automatic add_fetch(input int fw);
    for (int i = 0; i < fw; i++) push(3'd1, 1'b0, 1'b1, NZ, 1'b0, 1'b0, 1'b0);
    push(3'd1, 1'b1, 1'b1, NZ, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_instr(input logic ld, input logic st, input logic rw, input int fw, input int mw);
    add_fetch(fw);
    push(3'd2, 1'b1, 1'b1, {ld, st, rw, 2'b00}, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, NZ, st, rw, 1'b0);
    if (ld || st) begin
      for (int i = 0; i < mw; i++) push(3'd4, 1'b1, 1'b0, NZ, st, rw, 1'b0);
      push(3'd4, 1'b1, 1'b1, NZ, st, rw, 1'b0);
    end
    push(3'd5, 1'b1, 1'b1, NZ, st, rw, 1'b0);
  endtask

  task automatic clear_log();
    lg = 1;
    ir_m = 0; pc_m = 0; rf_m = 0; lr_m = 0; lw_m = 0; if_m = 0;
  endtask

  task automatic set_noise();
    ifu_ready = 1'b1;
    lsu_ready = 1'b1;
    {dec_load, dec_store, dec_regwrite, dec_ebreak, dec_illegal} = NZ;
  endtask

  task automatic run_queue();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      ifu_ready = e.ifr;
      lsu_ready = e.lsr;
      {dec_load, dec_store, dec_regwrite, dec_ebreak, dec_illegal} = e.fl;
      #1;
      cyc_no++;
      chk($sformatf("cycle %0d outputs", cyc_no), 64'(outs()), 64'(e.exp));
`ifdef YSYX_23060278_PERF_EN
      chk($sformatf("cycle %0d cycle_cnt", cyc_no), cycle_cnt, cyc_m);
      chk($sformatf("cycle %0d instret", cyc_no), instret, ret_m);
      if (e.exp[10:8] != 3'd0 && e.exp[10:8] != 3'd6) cyc_m++;
      if (e.exp[2]) ret_m++;
`endif
      if (lg < 32) begin
        st_log[lg] = state;
        ir_m[lg] = ir_we;
        pc_m[lg] = pc_we;
        rf_m[lg] = rf_we;
        lr_m[lg] = lsu_req;
        lw_m[lg] = lsu_we;
        if_m[lg] = ifu_req;
      end
      lg++;
    end
  endtask

  task automatic do_release();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after release state", 64'(state), 64'd0);
    clear_log();
    st_log[0] = state;
`ifdef YSYX_23060278_PERF_EN
    cyc_m = 0;
    ret_m = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_noise();
    #1;
    chk("reset outputs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    chk("reset held outputs", 64'(outs()), 64'd0);
    do_release();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] seq;
    set_noise();
    do_reset();

    add_instr(1'b0, 1'b0, 1'b1, 0, 0);
    add_instr(1'b0, 1'b0, 1'b1, 2, 0);
    add_instr(1'b0, 1'b0, 1'b1, 3, 0);
    add_fetch(0);
    push(3'd2, 1'b1, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, NZ, 1'b0, 1'b1, 1'b0);
    push(3'd4, 1'b1, 1'b0, NZ, 1'b0, 1'b1, 1'b0);
    push(3'd4, 1'b1, 1'b0, NZ, 1'b0, 1'b1, 1'b0);
    run_queue();
    chk("mid-mem lsu_req", 64'(lsu_req), 64'd1);
`ifdef YSYX_23060278_PERF_EN
    chk("instret after 3 alu", instret, 64'd3);
    chk("cycle_cnt mid-mem", cycle_cnt, 64'd21);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async lsu_req drop", 64'(lsu_req), 64'd0);
    chk("async reset outputs", 64'(outs()), 64'd0);
`ifdef YSYX_23060278_PERF_EN
    chk("reset perf", {cycle_cnt[31:0], instret[31:0]}, 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("in reset outputs", 64'(outs()), 64'd0);
    do_release();

    add_instr(1'b0, 1'b0, 1'b1, 0, 0);
    add_instr(1'b1, 1'b0, 1'b1, 0, 3);
    run_queue();
    seq = {st_log[0], st_log[1], st_log[2], st_log[3], st_log[4], st_log[5]};
    chk("alu state seq", 64'(seq), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1}));
    chk("alu+load ir_we mask", 64'(ir_m), 64'h22);
    chk("alu+load pc_we mask", 64'(pc_m), 64'h1010);
    chk("alu+load rf_we mask", 64'(rf_m), 64'h1010);
    chk("load lsu_req mask", 64'(lr_m), 64'hF00);
    chk("load lsu_we mask", 64'(lw_m), 64'h0);

    clear_log();
    add_instr(1'b0, 1'b1, 1'b1, 1, 2);
    run_queue();
    chk("store lsu_we mask", 64'(lw_m), 64'hE0);
    chk("store rf_we mask", 64'(rf_m), 64'h0);
    chk("store pc_we mask", 64'(pc_m), 64'h100);

    clear_log();
    add_fetch(0);
    push(3'd2, 1'b1, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(3'd6, 1'b1, 1'b1, NZ, 1'b0, 1'b0, 1'b0);
    run_queue();
    chk("ebreak halt/err", 64'({halt, err}), 64'b10);
    chk("ebreak ir_we mask", 64'(ir_m), 64'h2);

    do_reset();
    add_fetch(0);
    push(3'd2, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) push(3'd6, 1'b1, 1'b1, NZ, 1'b0, 1'b0, 1'b1);
    run_queue();
    chk("illegal halt/err", 64'({halt, err}), 64'b11);

    do_reset();
    for (int i = 0; i < 4; i++) push(3'd1, 1'b0, 1'b1, NZ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(3'd6, 1'b1, 1'b1, NZ, 1'b0, 1'b0, 1'b1);
    run_queue();
    chk("fetch timeout halt/err", 64'({halt, err}), 64'b11);
    chk("fetch timeout ifu_req mask", 64'(if_m), 64'h1E);

    do_reset();
    add_instr(1'b0, 1'b0, 1'b1, 3, 0);
    run_queue();
    chk("ready at limit ir_we mask", 64'(ir_m), 64'h10);
    chk("ready at limit pc_we mask", 64'(pc_m), 64'h80);
    chk("ready at limit err", 64'(err), 64'd0);

    do_reset();
    add_fetch(0);
    push(3'd2, 1'b1, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, NZ, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(3'd4, 1'b1, 1'b0, NZ, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) push(3'd6, 1'b1, 1'b1, NZ, 1'b0, 1'b0, 1'b1);
    run_queue();
    chk("mem timeout lsu_req mask", 64'(lr_m), 64'hF0);
    chk("mem timeout halt/err", 64'({halt, err}), 64'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
